// File: rtl/nv_nvdla_hs_pkg.sv
// rtl/nv_nvdla_hs_pkg.sv - shared types and constants for the four-phase handshake crossing
//
// Contents:
//   hs_state_e          handshake FSM state, 2-bit encoding
//   HS_SYNC_STAGES_DEF  default acknowledge synchronizer depth
//   HS_CNT_W            width of the completed-transfer counter
`timescale 1ns/1ps
package nv_nvdla_hs_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    REL  = 2'd2
  } hs_state_e;

  localparam int HS_SYNC_STAGES_DEF = 3;
  localparam int HS_CNT_W           = 16;

endpackage

// File: rtl/nv_nvdla_sync_bit.sv
// rtl/nv_nvdla_sync_bit.sv - N-flop single-bit synchronizer with async active-high reset
//
// Ports:
//   i_clk  in   destination clock
//   i_rst  in   asynchronous active-high reset, clears every stage
//   d      in   asynchronous input level
//   q      out  d after N flops of i_clk
`timescale 1ns/1ps
module nv_nvdla_sync_bit #(
  parameter int N = 3
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic d,
  output logic q
);

  logic [N-1:0] sync_q;
  logic [N-1:0] sync_d;

  // Stage 0 samples the asynchronous input; each later stage resolves metastability.
  always_comb begin
    sync_d = {sync_q[N-2:0], d};
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[N-1];

endmodule

// File: rtl/nv_nvdla_hs4_tx.sv
// rtl/nv_nvdla_hs4_tx.sv - source-side transmitter of a four-phase bundled-data handshake
//
// Ports:
//   i_clk     in   source-domain clock, rising edge
//   i_rst     in   asynchronous active-high reset
//   in_valid  in   word offered
//   in_ready  out  word accepted this cycle if in_valid
//   in_data   in   word to transmit
//   tx_req    out  request level toward the destination (flop output)
//   tx_data   out  bundled data held stable while a transfer is in flight (flop output)
//   tx_ack    in   acknowledge level from the destination, asynchronous
//   busy      out  transfer in flight
//   xfer_cnt  out  completed transfers, wraps
`timescale 1ns/1ps
module nv_nvdla_hs4_tx
  import nv_nvdla_hs_pkg::*;
#(
  parameter int DW          = 32,
  parameter int SYNC_STAGES = HS_SYNC_STAGES_DEF
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DW-1:0]       in_data,
  output logic                tx_req,
  output logic [DW-1:0]       tx_data,
  input  logic                tx_ack,
  output logic                busy,
  output logic [HS_CNT_W-1:0] xfer_cnt
);

  hs_state_e             state_q, state_d;
  logic                  tx_req_q, tx_req_d;
  logic [DW-1:0]         tx_data_q, tx_data_d;
  logic [HS_CNT_W-1:0]   xfer_cnt_q, xfer_cnt_d;
  logic                  ack_s;

  nv_nvdla_sync_bit #(
    .N (SYNC_STAGES)
  ) u_ack_sync (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .d     (tx_ack),
    .q     (ack_s)
  );

  // A still-high acknowledge in IDLE belongs to an earlier transfer (or an
  // unreset destination); starting a request over it would look complete at once.
  assign in_ready = (state_q == IDLE) & ~ack_s;
  assign busy     = (state_q != IDLE);

  always_comb begin
    state_d    = state_q;
    tx_req_d   = tx_req_q;
    tx_data_d  = tx_data_q;
    xfer_cnt_d = xfer_cnt_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          state_d   = REQ;
          tx_req_d  = 1'b1;
          tx_data_d = in_data;
        end
      end
      REQ: begin
        // A low ack here is either the normal wait or an illegal early drop;
        // both simply keep waiting for the rise.
        if (ack_s) begin
          state_d  = REL;
          tx_req_d = 1'b0;
        end
      end
      REL: begin
        if (!ack_s) begin
          state_d    = IDLE;
          xfer_cnt_d = xfer_cnt_q + 16'd1;
        end
      end
      default: begin
        state_d  = IDLE;
        tx_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= IDLE;
      tx_req_q   <= 1'b0;
      tx_data_q  <= '0;
      xfer_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      tx_req_q   <= tx_req_d;
      tx_data_q  <= tx_data_d;
      xfer_cnt_q <= xfer_cnt_d;
    end
  end

  assign tx_req   = tx_req_q;
  assign tx_data  = tx_data_q;
  assign xfer_cnt = xfer_cnt_q;

endmodule

// File: tb/tb_nv_nvdla_hs4_tx.sv
// tb/tb_nv_nvdla_hs4_tx.sv - self-checking bench for nv_nvdla_hs4_tx
`timescale 1ns/1ps
module tb_nv_nvdla_hs4_tx;

  localparam int DW = 32;
  localparam int S  = 3;

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          tx_req;
  logic [DW-1:0] tx_data;
  logic          tx_ack;
  logic          busy;
  logic [15:0]   xfer_cnt;

  logic          ack_drv  = 1'b0;
  logic          dest_en  = 1'b0;
  logic          dest_ack = 1'b0;
  logic [S-1:0]  dsync    = '0;
  logic          dclk     = 1'b0;
  real           dhalf    = 13.5;

  int            n_vec = 0;
  int            n_err = 0;
  int            cyc   = 0;
  int            n_rx  = 0;
  logic [31:0]   exp_q[$];

  nv_nvdla_hs4_tx #(
    .DW          (DW),
    .SYNC_STAGES (S)
  ) dut (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .tx_req   (tx_req),
    .tx_data  (tx_data),
    .tx_ack   (tx_ack),
    .busy     (busy),
    .xfer_cnt (xfer_cnt)
  );

  always #5 i_clk = ~i_clk;
  always #(dhalf) dclk = ~dclk;

  always @(posedge i_clk) cyc <= cyc + 1;

  assign tx_ack = dest_en ? dest_ack : ack_drv;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Destination model on its own clock: 3-flop sync of tx_req, capture on req,
  // ack, release when req falls. Each captured word is checked against the scoreboard.
  always @(posedge dclk) begin
    if (!dest_en) begin
      dsync    <= '0;
      dest_ack <= 1'b0;
    end else begin
      dsync <= {dsync[S-2:0], tx_req};
      if (dsync[S-1] && !dest_ack) begin
        logic [31:0] e;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : ~tx_data;
        n_rx++;
        chk("rx_word", tx_data, e);
        dest_ack <= 1'b1;
      end else if (!dsync[S-1] && dest_ack) begin
        dest_ack <= 1'b0;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset(input logic ack_level);
    @(negedge i_clk);
    ack_drv  = ack_level;
    in_valid = 1'b0;
    i_rst    = 1'b1;
    repeat (2) @(negedge i_clk);
    i_rst = 1'b0;
  endtask

  task automatic xfer_direct(input logic [31:0] w);
    int t;
    @(negedge i_clk);
    in_valid = 1'b1;
    in_data  = w;
    t = 0;
    while (!in_ready && t < 100) begin @(negedge i_clk); t++; end
    chk("xd_ready", in_ready, 1);
    @(negedge i_clk);
    in_valid = 1'b0;
    chk("xd_req", tx_req, 1);
    chk("xd_data", tx_data, w);
    ack_drv = 1'b1;
    t = 0;
    while (tx_req && t < 100) begin @(negedge i_clk); t++; end
    chk("xd_req_fall", tx_req, 0);
    ack_drv = 1'b0;
    t = 0;
    while (!in_ready && t < 100) begin @(negedge i_clk); t++; end
    chk("xd_idle", in_ready, 1);
  endtask

  initial begin
    int k, fall, m, t;
    logic [31:0] w;

    i_rst    = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;

    // Reset release with ack low
    repeat (3) @(negedge i_clk);
    i_rst = 1'b0;
    @(negedge i_clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_tx_req", tx_req, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_xfer_cnt", xfer_cnt, 0);
    chk("rst_busy", busy, 0);

    // Single word, destination acks 2 cycles after req and releases 2 after req falls
    in_valid = 1'b1;
    in_data  = 32'hDEADBEEF;
    @(negedge i_clk);
    k = cyc;
    in_valid = 1'b0;
    in_data  = 32'h0;
    chk("sw_req", tx_req, 1);
    chk("sw_data", tx_data, 32'hDEADBEEF);
    chk("sw_busy", busy, 1);
    chk("sw_not_ready", in_ready, 0);
    repeat (2) @(negedge i_clk);
    ack_drv = 1'b1;
    t = 0;
    while (tx_req && t < 200) begin @(negedge i_clk); t++; end
    fall = cyc;
    chk("sw_req_fall_edge", fall, k + 3 + S);
    chk("sw_data_rel", tx_data, 32'hDEADBEEF);
    chk("sw_busy_rel", busy, 1);
    repeat (2) @(negedge i_clk);
    ack_drv = 1'b0;
    t = 0;
    while (!in_ready && t < 200) begin @(negedge i_clk); t++; end
    chk("sw_ready_edge", cyc, fall + 3 + S);
    chk("sw_xfer_cnt", xfer_cnt, 1);
    chk("sw_data_hold", tx_data, 32'hDEADBEEF);
    chk("sw_idle_busy", busy, 0);

    // Stale ack held through reset release
    do_reset(1'b1);
    repeat (S + 1) @(negedge i_clk);
    chk("stale_not_ready", in_ready, 0);
    in_valid = 1'b1;
    in_data  = 32'h12345678;
    repeat (6) @(negedge i_clk);
    chk("stale_no_req", tx_req, 0);
    chk("stale_no_busy", busy, 0);
    chk("stale_no_capture", tx_data, 0);
    in_valid = 1'b0;
    ack_drv  = 1'b0;
    m = cyc;
    t = 0;
    while (!in_ready && t < 50) begin @(negedge i_clk); t++; end
    chk("stale_ready_edge", cyc, m + S);

    // Reset asserted while in REQ, ack raised
    in_valid = 1'b1;
    in_data  = 32'hA5A5A5A5;
    @(negedge i_clk);
    in_valid = 1'b0;
    chk("mid_req", tx_req, 1);
    ack_drv = 1'b1;
    #2 i_rst = 1'b1;
    #1;
    chk("mid_async_req", tx_req, 0);
    chk("mid_async_busy", busy, 0);
    chk("mid_async_data", tx_data, 0);
    @(negedge i_clk);
    i_rst = 1'b0;
    repeat (S + 1) @(negedge i_clk);
    chk("mid_stale_ready", in_ready, 0);
    in_valid = 1'b1;
    in_data  = 32'h0BADF00D;
    repeat (5) @(negedge i_clk);
    chk("mid_no_req", tx_req, 0);
    in_valid = 1'b0;
    ack_drv  = 1'b0;
    repeat (S + 1) @(negedge i_clk);
    chk("mid_ready_back", in_ready, 1);
    chk("mid_xfer_cnt", xfer_cnt, 0);

    // Streams of 20 random words to a destination at 0.37x and 2.9x frequency
    for (int pass = 0; pass < 2; pass++) begin
      do_reset(1'b0);
      dhalf = (pass == 0) ? 13.5 : 1.725;
      n_rx  = 0;
      exp_q.delete();
      dest_en = 1'b1;
      for (int n = 0; n < 20; n++) begin
        w = $urandom;
        @(negedge i_clk);
        in_valid = 1'b1;
        in_data  = w;
        t = 0;
        while (!in_ready && t < 2000) begin @(negedge i_clk); t++; end
        chk("st_accept", in_ready, 1);
        exp_q.push_back(w);
        @(negedge i_clk);
        in_valid = 1'b0;
      end
      t = 0;
      while (!(n_rx == 20 && !busy && in_ready) && t < 5000) begin @(negedge i_clk); t++; end
      chk("st_rx_count", n_rx, 20);
      chk("st_left_over", exp_q.size(), 0);
      chk("st_xfer_cnt", xfer_cnt, 20);
      dest_en = 1'b0;
      repeat (4) @(negedge i_clk);
    end

    // Counter wrap from a forced 0xFFFF
    @(negedge i_clk);
    force dut.xfer_cnt_q = 16'hFFFF;
    @(negedge i_clk);
    release dut.xfer_cnt_q;
    @(negedge i_clk);
    chk("wrap_preload", xfer_cnt, 16'hFFFF);
    xfer_direct(32'hCAFEF00D);
    chk("wrap_cnt", xfer_cnt, 0);
    chk("wrap_data", tx_data, 32'hCAFEF00D);
    chk("wrap_req", tx_req, 0);
    chk("wrap_busy", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
